// File: rtl/pipe_reg_chain_pkg.sv
// Shared types and sizing helpers for the elastic register chain.
package pipe_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Bits needed to hold an occupancy of 0..2*stages.
  function automatic int unsigned count_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_skid_stage.sv
// One two-entry skid stage: ready comes straight from state flops so the
// upstream ready path never sees downstream combinational logic.
module skid_stage
  import pipe_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o,
  output logic [1:0]       occ_d_o
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_valid_i) begin
            state_d = BUSY;
            main_d  = up_data_i;
          end
        end
        BUSY: begin
          if (up_valid_i && dn_ready_i) begin
            main_d = up_data_i;
          end else if (up_valid_i && !dn_ready_i) begin
            state_d = FULL;
            skid_d  = up_data_i;
          end else if (!up_valid_i && dn_ready_i) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dn_ready_i) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Next-state occupancy lets the parent register a count aligned with state.
  always_comb begin
    occ_d_o = 2'd0;
    if (state_d == BUSY) occ_d_o = 2'd1;
    else if (state_d == FULL) occ_d_o = 2'd2;
  end

  assign up_ready_o = (state_q != FULL);
  assign dn_valid_o = (state_q != EMPTY);
  assign dn_data_o  = main_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain of STAGES skid stages with flush and
// a registered occupancy count.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [count_width(STAGES)-1:0]    count
);

  localparam int unsigned CntW = count_width(STAGES);

  logic             stg_valid [STAGES+1];
  logic             stg_ready [STAGES+1];
  logic [WIDTH-1:0] stg_data  [STAGES+1];
  logic [1:0]       stg_occ   [STAGES];
  logic [CntW-1:0]  count_q, count_d;

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = in_data;
  assign stg_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    skid_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid_i (stg_valid[i]),
      .up_ready_o (stg_ready[i]),
      .up_data_i  (stg_data[i]),
      .dn_valid_o (stg_valid[i+1]),
      .dn_ready_i (stg_ready[i+1]),
      .dn_data_o  (stg_data[i+1]),
      .occ_d_o    (stg_occ[i])
    );
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      count_d = count_d + CntW'(stg_occ[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign in_ready  = stg_ready[0] & ~flush;
  assign out_valid = stg_valid[STAGES];
  assign out_data  = stg_data[STAGES];
  assign count     = count_q;

endmodule
